// File: rtl/regbus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regbus_sequencer_pkg
// Description : Shared constants, table entry type and FSM encoding for the
//               register-bus sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package regbus_sequencer_pkg;

    // Own register window: word address bits [11:10] == 2'b11
    localparam logic [1:0] c_own_base  = 2'b11;

    // Offsets inside the own window (word address bits [9:0])
    localparam logic [9:0] c_off_ctrl  = 10'h000;
    localparam logic [9:0] c_off_runs  = 10'h001;
    localparam logic [9:0] c_off_table = 10'h010;

    // Table index width: enough for the deepest supported table (15)
    localparam int c_idx_w = 4;

    // One table entry: peripheral word address plus write data (44 bits)
    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } seq_entry_t;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_LOW = 2'd3
    } seq_state_t;

    // Table slot for an own-window offset: entries occupy offset pairs
    // starting at c_off_table (even = address, odd = data).
    function automatic logic [8:0] table_slot(input logic [9:0] off);
        return 9'((off - c_off_table) >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regbus_seq_table.sv
`default_nettype none
// ============================================================================
// Module      : regbus_seq_table
// Description : N_ENTRIES x 44-bit write table. One host write port (address
//               and data halves written separately), two combinational read
//               ports (host readback and sequencer issue).
// Revision    : 1.0 - initial release
// ============================================================================
module regbus_seq_table
    import regbus_sequencer_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               wr_addr_en,
    input  logic               wr_data_en,
    input  logic [c_idx_w-1:0] wr_idx,
    input  logic [31:0]        wr_data,
    input  logic [c_idx_w-1:0] host_idx,
    output seq_entry_t         host_entry,
    input  logic [c_idx_w-1:0] seq_idx,
    output seq_entry_t         seq_entry
);

    seq_entry_t r_entry [N_ENTRIES];

    // Register file: cleared on reset, host writes one half per access
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (wr_addr_en && (wr_idx == c_idx_w'(i))) begin
                    r_entry[i].addr <= wr_data[11:0];
                end
                if (wr_data_en && (wr_idx == c_idx_w'(i))) begin
                    r_entry[i].data <= wr_data;
                end
            end
        end
    end

    // Read ports: out-of-range indices return zero
    always_comb begin
        host_entry = '0;
        seq_entry  = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (host_idx == c_idx_w'(i)) begin
                host_entry = r_entry[i];
            end
            if (seq_idx == c_idx_w'(i)) begin
                seq_entry = r_entry[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regbus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regbus_sequencer
// Description : Arbitrates the 12-bit word-addressed peripheral register bus
//               between the host bridge and a write sequencer that replays a
//               programmed table whenever the timing-change status rises.
// Revision    : 1.0 - initial release
// ============================================================================
module regbus_sequencer
    import regbus_sequencer_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        h_valid,
    input  logic        h_wr,
    input  logic [11:0] h_addr,
    input  logic [31:0] h_wdata,
    output logic [31:0] h_rdata,
    output logic        h_rvalid,
    output logic        b_valid,
    output logic        b_wr,
    output logic [11:0] b_addr,
    output logic [31:0] b_wdata,
    input  logic [31:0] b_rdata,
    input  logic        trig,
    output logic        trig_ack,
    output logic        busy
);

    localparam logic [c_idx_w-1:0] c_n = c_idx_w'(N_ENTRIES);

    seq_state_t         r_state;
    seq_state_t         w_state_nx;
    logic [c_idx_w-1:0] r_idx;
    logic [c_idx_w-1:0] w_idx_nx;
    logic               w_seq_issue;

    logic               r_en;
    logic [3:0]         r_count;
    logic [15:0]        r_runs;
    logic [c_idx_w-1:0] w_eff;

    // Host-side decode in the issue cycle
    logic               w_own;
    logic [9:0]         w_off;
    logic [8:0]         w_slot;
    logic               w_slot_ok;
    logic               w_own_wr;
    logic               w_ctrl_wr;
    logic               w_tbl_wr;

    // Host pipeline stage 1 (bus cycle / own-register read cycle)
    logic               r_host_pend;
    logic               r_per_rd;
    logic               r_own_rd;
    logic [9:0]         r_own_off;
    logic [8:0]         w_rd_slot;
    logic               w_rd_slot_ok;
    logic [31:0]        w_own_rdata;

    seq_entry_t         w_host_entry;
    seq_entry_t         w_seq_entry;

    assign w_own     = (h_addr[11:10] == c_own_base);
    assign w_off     = h_addr[9:0];
    assign w_slot    = table_slot(w_off);
    assign w_slot_ok = (w_off >= c_off_table) && (w_slot < 9'(N_ENTRIES));
    assign w_own_wr  = h_valid && h_wr && w_own;
    assign w_ctrl_wr = w_own_wr && (w_off == c_off_ctrl);
    assign w_tbl_wr  = w_own_wr && w_slot_ok;

    assign w_rd_slot    = table_slot(r_own_off);
    assign w_rd_slot_ok = (r_own_off >= c_off_table) && (w_rd_slot < 9'(N_ENTRIES));

    assign w_eff = (r_count > c_n) ? c_n : r_count;
    assign busy  = (r_state != ST_IDLE);

    regbus_seq_table #(
        .N_ENTRIES (N_ENTRIES)
    ) u_table (
        .clk        (clk),
        .nreset     (nreset),
        .wr_addr_en (w_tbl_wr && !w_off[0]),
        .wr_data_en (w_tbl_wr && w_off[0]),
        .wr_idx     (w_slot[c_idx_w-1:0]),
        .wr_data    (h_wdata),
        .host_idx   (w_rd_slot[c_idx_w-1:0]),
        .host_entry (w_host_entry),
        .seq_idx    (r_idx),
        .seq_entry  (w_seq_entry)
    );

    // CTRL register: host writes apply at the end of the access cycle
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_en    <= 1'b0;
            r_count <= 4'd0;
        end else if (w_ctrl_wr) begin
            r_en    <= h_wdata[0];
            r_count <= h_wdata[11:8];
        end
    end

    // FSM state and table index register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    // FSM next state; a sequencer op may only take a cycle free of host ops
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_seq_issue = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_en && trig) begin
                    w_idx_nx   = '0;
                    w_state_nx = (w_eff == '0) ? ST_ACK : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!r_en) begin
                    w_state_nx = ST_IDLE;
                end else if (!h_valid) begin
                    w_seq_issue = 1'b1;
                    // >= rather than == keeps the run finite if COUNT shrinks mid-run
                    if (({1'b0, r_idx} + 5'd1) >= {1'b0, w_eff}) begin
                        w_state_nx = ST_ACK;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            ST_ACK: begin
                w_state_nx = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!trig) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Acknowledge pulse and completed-run counter
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            trig_ack <= 1'b0;
            r_runs   <= 16'd0;
        end else begin
            trig_ack <= (r_state == ST_ACK);
            if (r_state == ST_ACK) begin
                r_runs <= r_runs + 16'd1;
            end
        end
    end

    // Issue stage: host peripheral op has priority over the sequencer
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            b_valid <= 1'b0;
            b_wr    <= 1'b0;
            b_addr  <= 12'd0;
            b_wdata <= 32'd0;
        end else if (h_valid && !w_own) begin
            b_valid <= 1'b1;
            b_wr    <= h_wr;
            b_addr  <= h_addr;
            b_wdata <= h_wdata;
        end else if (w_seq_issue) begin
            b_valid <= 1'b1;
            b_wr    <= 1'b1;
            b_addr  <= w_seq_entry.addr;
            b_wdata <= w_seq_entry.data;
        end else begin
            b_valid <= 1'b0;
            b_wr    <= 1'b0;
            b_addr  <= 12'd0;
            b_wdata <= 32'd0;
        end
    end

    // Host pipeline stage 1: remember what kind of response is owed
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_host_pend <= 1'b0;
            r_per_rd    <= 1'b0;
            r_own_rd    <= 1'b0;
            r_own_off   <= 10'd0;
        end else begin
            r_host_pend <= h_valid;
            r_per_rd    <= h_valid && !h_wr && !w_own;
            r_own_rd    <= h_valid && !h_wr && w_own;
            r_own_off   <= w_off;
        end
    end

    // Own-register read mux, evaluated in the cycle after the request
    always_comb begin
        w_own_rdata = 32'd0;
        if (r_own_off == c_off_ctrl) begin
            w_own_rdata = {busy, 11'd0, r_idx, 4'd0, r_count, 7'd0, r_en};
        end else if (r_own_off == c_off_runs) begin
            w_own_rdata = {16'd0, r_runs};
        end else if (w_rd_slot_ok) begin
            w_own_rdata = r_own_off[0] ? w_host_entry.data : {20'd0, w_host_entry.addr};
        end
    end

    // Host pipeline stage 2: response; writes return zero
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            h_rvalid <= 1'b0;
            h_rdata  <= 32'd0;
        end else begin
            h_rvalid <= r_host_pend;
            if (r_per_rd) begin
                h_rdata <= b_rdata;
            end else if (r_own_rd) begin
                h_rdata <= w_own_rdata;
            end else begin
                h_rdata <= 32'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regbus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbus_sequencer
// Description : Self-checking bench: transaction-level model of the host
//               pipeline, register map and expected sequencer writes, with
//               directed scenarios and literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbus_sequencer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        h_valid = 1'b0;
    logic        h_wr = 1'b0;
    logic [11:0] h_addr = 12'd0;
    logic [31:0] h_wdata = 32'd0;
    logic [31:0] h_rdata;
    logic        h_rvalid;
    logic        b_valid;
    logic        b_wr;
    logic [11:0] b_addr;
    logic [31:0] b_wdata;
    logic [31:0] b_rdata;
    logic        trig = 1'b0;
    logic        trig_ack;
    logic        busy;

    always #5 clk = ~clk;

    // Peripheral read data is a fixed function of the address
    assign b_rdata = {b_addr, 8'h5A, b_addr};

    regbus_sequencer #(.N_ENTRIES(N)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .h_valid  (h_valid),
        .h_wr     (h_wr),
        .h_addr   (h_addr),
        .h_wdata  (h_wdata),
        .h_rdata  (h_rdata),
        .h_rvalid (h_rvalid),
        .b_valid  (b_valid),
        .b_wr     (b_wr),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_rdata  (b_rdata),
        .trig     (trig),
        .trig_ack (trig_ack),
        .busy     (busy)
    );

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int seq_writes = 0;

    // Model of the register map
    logic        m_en;
    logic [3:0]  m_count;
    logic [3:0]  m_idx;
    logic [15:0] m_runs;
    logic [11:0] m_ta [N];
    logic [31:0] m_td [N];

    typedef struct {
        bit          v;
        bit          wr;
        bit          own;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } hop_t;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t  exp_q [$];
    hop_t h1, h2, cur;
    bit   prev_ack;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Own-window read value from the register map description
    function automatic logic [31:0] own_val(input logic [11:0] a);
        int off;
        int i;
        off = int'(a) - 'hC00;
        if (off == 0) return {1'b0, 11'd0, m_idx, 4'd0, m_count, 7'd0, m_en};
        if (off == 1) return {16'd0, m_runs};
        if (off >= 16) begin
            i = (off - 16) / 2;
            if (i < N) return (off % 2 == 1) ? m_td[i] : {20'd0, m_ta[i]};
        end
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_en = 1'b0;
        m_count = 4'd0;
        m_idx = 4'd0;
        m_runs = 16'd0;
        for (int i = 0; i < N; i++) begin
            m_ta[i] = 12'd0;
            m_td[i] = 32'd0;
        end
    endtask

    // Compare process: host responses, bus ops and ack pulses every cycle
    always @(negedge clk) begin
        if (!nreset) begin
            h1.v = 0;
            h2.v = 0;
            prev_ack = 0;
            exp_q.delete();
            model_reset();
        end else begin
            if (h1.v && !h1.own) begin
                chk(b_valid && (b_wr == h1.wr) && (b_addr == h1.a) && (b_wdata == h1.d),
                    "host_bus_op", {b_valid, 7'd0, 12'd0, b_addr}, {8'h80, 12'd0, h1.a});
            end else if (h1.v) begin
                chk(!b_valid, "own_op_bus_idle", 32'(b_valid), 32'd0);
            end else if (b_valid) begin
                chk(exp_q.size() > 0, "seq_op_expected", {20'd0, b_addr}, 32'd0);
                if (exp_q.size() > 0) begin
                    chk(b_wr && (b_addr == exp_q[0].a) && (b_wdata == exp_q[0].d),
                        "seq_write", b_wdata, exp_q[0].d);
                    void'(exp_q.pop_front());
                    seq_writes++;
                end
            end

            if (h2.v) begin
                chk(h_rvalid && (h_rdata == h2.exp), "host_resp", h_rdata, h2.exp);
            end else begin
                chk(!h_rvalid, "rvalid_idle", 32'(h_rvalid), 32'd0);
            end

            if (trig_ack) begin
                ack_cnt++;
                chk(!prev_ack, "ack_single_cycle", 32'(prev_ack), 32'd0);
            end
            prev_ack = trig_ack;

            if (h1.v) begin
                h1.exp = h1.wr ? 32'd0 : (h1.own ? own_val(h1.a) : {h1.a, 8'h5A, h1.a});
            end
            h2 = h1;
            cur.v   = h_valid;
            cur.wr  = h_wr;
            cur.own = (h_addr[11:10] == 2'b11);
            cur.a   = h_addr;
            cur.d   = h_wdata;
            cur.exp = 32'd0;
            h1 = cur;

            if (cur.v && cur.wr && cur.own) begin
                int off;
                int i;
                off = int'(cur.a) - 'hC00;
                if (off == 0) begin
                    m_en = cur.d[0];
                    m_count = cur.d[11:8];
                end else if (off >= 16) begin
                    i = (off - 16) / 2;
                    if (i < N) begin
                        if (off % 2 == 1) m_td[i] = cur.d;
                        else m_ta[i] = cur.d[11:0];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host(input bit wr, input logic [11:0] a, input logic [31:0] d);
        h_valid = 1'b1;
        h_wr = wr;
        h_addr = a;
        h_wdata = d;
        tick();
        h_valid = 1'b0;
        h_wr = 1'b0;
        h_addr = 12'd0;
        h_wdata = 32'd0;
    endtask

    task automatic rd_lit(input logic [11:0] a, input logic [31:0] exp, input string name);
        host(1'b0, a, 32'd0);
        tick();
        chk(h_rvalid && (h_rdata == exp), name, h_rdata, exp);
    endtask

    task automatic prog(input int i, input logic [11:0] a, input logic [31:0] d);
        host(1'b1, 12'(12'hC10 + 2 * i), {20'd0, a});
        host(1'b1, 12'(12'hC11 + 2 * i), d);
    endtask

    task automatic push_run();
        wr_t w;
        for (int i = 0; i < min_int(int'(m_count), N); i++) begin
            w.a = m_ta[i];
            w.d = m_td[i];
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_ack(input int bound, output int lat);
        lat = 0;
        while (trig_ack !== 1'b1 && lat < bound) begin
            tick();
            lat++;
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({h_rvalid, b_valid, b_wr, trig_ack, busy} == 5'd0 && h_rdata == 0 &&
            b_addr == 0 && b_wdata == 0, name,
            {h_rdata[15:0], 7'd0, h_rvalid, b_valid, b_wr, trig_ack, busy, b_addr[3:0]}, 32'd0);
    endtask

    initial begin
        int lat;
        int ack0;
        int sw0;
        wr_t w;

        model_reset();
        repeat (3) tick();
        chk_outputs_zero("reset_outputs");
        nreset = 1'b1;
        tick();

        // Reset values of own registers
        rd_lit(12'hC00, 32'd0, "ctrl_reset");
        rd_lit(12'hC01, 32'd0, "runs_reset");

        // Three-entry run, no traffic
        prog(0, 12'h800, 32'h11);
        prog(1, 12'h801, 32'h22);
        prog(2, 12'h802, 32'h33);
        host(1'b1, 12'hC00, 32'h301);
        rd_lit(12'hC13, 32'h22, "table_readback");
        push_run();
        trig = 1'b1;
        wait_ack(20, lat);
        chk(trig_ack === 1'b1 && lat == 5, "ack_latency_3", 32'(lat), 32'd5);
        m_runs = 16'd1;
        m_idx = 4'd2;
        repeat (10) tick();
        chk(ack_cnt == 1, "no_retrigger_held", 32'(ack_cnt), 32'd1);
        chk(exp_q.size() == 0, "run1_all_written", 32'(exp_q.size()), 32'd0);
        trig = 1'b0;
        repeat (2) tick();
        rd_lit(12'hC01, 32'd1, "runs_after_1");
        rd_lit(12'hC00, 32'h0002_0301, "ctrl_after_run");

        // Second run with host peripheral reads every 4th cycle
        push_run();
        trig = 1'b1;
        for (int i = 0; i < 16; i++) begin
            h_valid = (i % 4 == 1);
            h_wr = 1'b0;
            h_addr = (i % 4 == 1) ? 12'h020 : 12'h000;
            tick();
        end
        h_valid = 1'b0;
        h_addr = 12'd0;
        repeat (3) tick();
        chk(ack_cnt == 2, "traffic_run_ack", 32'(ack_cnt), 32'd2);
        chk(exp_q.size() == 0, "traffic_run_none_lost", 32'(exp_q.size()), 32'd0);
        m_runs = 16'd2;
        trig = 1'b0;
        repeat (2) tick();
        rd_lit(12'hC01, 32'd2, "runs_after_2");
        rd_lit(12'h020, 32'h0205_A020, "periph_read");

        // COUNT = 0: ack without bus writes
        host(1'b1, 12'hC00, 32'h001);
        tick();
        sw0 = seq_writes;
        trig = 1'b1;
        wait_ack(10, lat);
        chk(trig_ack === 1'b1 && lat == 2, "ack_latency_0", 32'(lat), 32'd2);
        m_runs = 16'd3;
        m_idx = 4'd0;
        repeat (4) tick();
        chk(seq_writes == sw0, "count0_no_writes", 32'(seq_writes - sw0), 32'd0);
        trig = 1'b0;
        repeat (2) tick();

        // COUNT = 15 clamps to the table depth; slot 8 does not exist
        for (int i = 3; i < N; i++) begin
            prog(i, 12'(12'h800 + i), 32'(32'h11 * (i + 1)));
        end
        prog(8, 12'h8FF, 32'hDEAD_BEEF);
        rd_lit(12'hC21, 32'd0, "out_of_range_read");
        host(1'b1, 12'hC00, 32'hF01);
        tick();
        sw0 = seq_writes;
        push_run();
        trig = 1'b1;
        wait_ack(30, lat);
        chk(trig_ack === 1'b1 && lat == 10, "ack_latency_8", 32'(lat), 32'd10);
        m_runs = 16'd4;
        m_idx = 4'd7;
        repeat (3) tick();
        chk(seq_writes - sw0 == 8, "count15_writes", 32'(seq_writes - sw0), 32'd8);
        trig = 1'b0;
        repeat (2) tick();
        rd_lit(12'hC00, 32'h0007_0F01, "ctrl_count15");
        rd_lit(12'hC01, 32'd4, "runs_after_4");

        // Abort by clearing EN after the first write
        ack0 = ack_cnt;
        sw0 = seq_writes;
        w.a = m_ta[0];
        w.d = m_td[0];
        exp_q.push_back(w);
        trig = 1'b1;
        tick();
        tick();
        host(1'b1, 12'hC00, 32'hF00);
        repeat (10) tick();
        chk(ack_cnt == ack0, "abort_no_ack", 32'(ack_cnt - ack0), 32'd0);
        chk(seq_writes - sw0 == 1, "abort_one_write", 32'(seq_writes - sw0), 32'd1);
        m_idx = 4'd1;
        trig = 1'b0;
        repeat (2) tick();
        rd_lit(12'hC00, 32'h0001_0F00, "ctrl_after_abort");

        // Reset in the middle of a run
        host(1'b1, 12'hC00, 32'hF01);
        tick();
        push_run();
        trig = 1'b1;
        repeat (3) tick();
        nreset = 1'b0;
        tick();
        chk_outputs_zero("midrun_reset_outputs");
        trig = 1'b0;
        nreset = 1'b1;
        tick();
        rd_lit(12'hC11, 32'd0, "table_cleared");
        rd_lit(12'hC01, 32'd0, "runs_cleared");
        rd_lit(12'hC00, 32'd0, "ctrl_cleared");
        repeat (4) tick();
        chk(exp_q.size() == 0, "final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regbus_sequencer.md
# regbus_sequencer

Arbitrates the 12-bit word-addressed peripheral register bus between the SPI register bridge (host) and an internal write sequencer. When VIDC timing registers change (tregs_status), the sequencer replays a host-programmed table of up to N_ENTRIES register writes, such as video timing or scaler setup. It then acknowledges the change, so mode switches are applied without an MCU round-trip. It sits between `spir` and the peripheral decode (VIDC capture and video regs) and owns word window 0xC00–0xFFF (`iomem_addr[13:12]==2'b11`).

## Interface
- N_ENTRIES, 8: table depth, 1–15
- clk  in  1  system clock
- nreset  in  1  asynchronous, active-low reset
- h_valid  in  1  host access strobe, single-cycle
- h_wr  in  1  host write (1) or read (0)
- h_addr  in  12  host word address
- h_wdata  in  32  host write data
- h_rdata  out  32  host read data, registered
- h_rvalid  out  1  host access complete, 1-cycle pulse
- b_valid  out  1  peripheral bus strobe
- b_wr  out  1  peripheral write
- b_addr  out  12  peripheral word address
- b_wdata  out  32  peripheral write data
- b_rdata  in  32  peripheral read data, combinational, valid in the b_valid cycle
- trig  in  1  VIDC timing-registers-changed status
- trig_ack  out  1  acknowledge, 1-cycle pulse
- busy  out  1  sequencer not IDLE

## Operation
- Own registers are selected by `h_addr[11:10]==2'b11` and never appear on b_*.
  - 0xC00 CTRL: bit0 EN, bits 11:8 COUNT. Reads as {busy at bit31, IDX[3:0] at bits 19:16, COUNT, EN}.
  - 0xC01 RUNS: 16-bit count of completed sequences, wraps at 0xFFFF→0. Read-only; writes are ignored.
  - 0xC10+2i: entry i address [11:0]. 0xC11+2i: entry i data [31:0]. Accesses with i≥N_ENTRIES read 0 and ignore writes.
- Arbitration: fixed priority, host first. A sequencer op issues only in a cycle with no host op in the issue stage. It retries every following cycle until issued, so it cannot starve at the SPI access rate.
- Effective count = min(COUNT, N_ENTRIES).
- FSM:
  - IDLE: when EN & trig, set IDX=0 and go to RUN; if effective count is 0, go to ACK instead.
  - RUN: each issued op writes entry[IDX]. When IDX reaches effective count−1 at issue, go to ACK; otherwise IDX++. If EN clears, abort after any op already issued: no ack, go to IDLE.
  - ACK: trig_ack=1 for one cycle, RUNS++, go to WAIT_LOW.
  - WAIT_LOW: when trig=0, go to IDLE. This prevents double-triggering on a held status.
- Table and CTRL writes take effect immediately, including while RUN is active. Each entry is read at its issue cycle.
- Host reads of peripherals return b_rdata; reads of own registers return the values above. The host write response returns h_rdata=0.

## Timing
- Host op with h_valid at cycle T:
  - Peripheral access: b_valid=1 at T+1.
  - h_rvalid=1 at T+2 for both peripheral and own-register accesses; h_rdata is captured at the T+1 edge.
- Sequencer op: b_valid, b_wr=1, b_addr and b_wdata are registered outputs, asserted for exactly one cycle per op.
- b_valid is never asserted on two consecutive cycles for the same op.
- A host op arriving in the same cycle a sequencer op would be selected wins; the sequencer op moves to the next free cycle.
- Minimum trigger-to-ack latency, in cycles with no host traffic: effective count + 2.
- Reset values:
  - Outputs: all 0.
  - State and registers: FSM=IDLE, IDX=0, EN=0, COUNT=0, RUNS=0, table entries 0.
- Asserting nreset mid-sequence aborts immediately; no ack is issued.

## Structure
- Shared package holds the own-window base (2'b11 at addr[11:10]), CTRL/RUNS/table offsets, and the FSM state encoding.
- One sub-module, `regbus_seq_table`: N_ENTRIES×44-bit register file with one host write port and two combinational read ports (host readback, sequencer).
- The arbiter, issue stage and FSM live in the top of the block.

## Test plan
- After reset, host reads 0xC00 and 0xC01 → h_rdata=0, h_rvalid at T+2, b_valid never asserted.
- Program 3 entries (0x800→0x11, 0x801→0x22, 0x802→0x33), set CTRL=0x301, then raise trig → three b_valid writes in order, then trig_ack one cycle later, RUNS=1.
- During RUN, hold h_valid reads of 0x020 on every 4th cycle → each host read appears on the bus at T+1 and returns b_rdata at T+2. Sequencer writes fill the remaining cycles, stay in order, and none is lost.
- Hold trig high after ack → no second run. Drop trig, raise it again → second run, RUNS=2.
- Set COUNT=0 and EN=1, raise trig → no bus writes, trig_ack pulses. Set COUNT=15 with N_ENTRIES=8 → exactly 8 writes.
- Clear EN mid-sequence after 1 write → go to IDLE, no ack. Deassert nreset mid-RUN → all outputs 0 on the following edge, table cleared.
